inject_scheduler: RTL and testbench
===================================

Name: inject_scheduler

Overview:
- Sequencing controller for the router's local-injection path.
- Buffers flit addresses from the local core in a small FIFO and watches which of the four router input slots are empty each cycle.
- Grants one empty slot per cycle to the FIFO head, using rotating priority.
- Tracks local starvation and raises a throttle request when no slot has been free for too long.

Parameters:
- ADDR_W, 10, flit address/header width.
- DEPTH, 4, local FIFO entries; power of two, at least 2.
- STARVE_LIM, 8, consecutive blocked cycles before starve_req asserts; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- loc_valid  in  1  local core offers a flit.
- loc_ad  in  ADDR_W  local flit address.
- loc_ready  out  1  FIFO can accept; a transfer occurs when loc_valid && loc_ready at a clk edge.
- in_valid  in  4  slot occupancy; bit 0 east, 1 west, 2 north, 3 south. 1 = occupied.
- inj_valid  out  1  head flit is injected this cycle.
- inj_sel  out  4  one-hot granted slot, same bit order as in_valid; all zero when inj_valid=0.
- inj_ad  out  ADDR_W  head address when inj_valid=1, else 0.
- starve_req  out  1  registered throttle request to neighbours.
- occupancy  out  clog2(DEPTH)+1  current FIFO count.

Behaviour:
- Reset, asynchronous, rst_n=0: FIFO count=0, rd/wr pointers=0, priority pointer ptr=0, starve counter=0, state=IDLE.
  - Output values during and after reset: loc_ready=1, inj_valid=0, inj_sel=0, inj_ad=0, starve_req=0, occupancy=0.
  - Reset mid-operation discards all buffered flits.
- loc_ready = (count < DEPTH), combinational. A full FIFO does not bypass, so loc_ready=0 when full even if a dequeue occurs that cycle.
- Injection decision is combinational from the FIFO head, in_valid and ptr:
  - free = ~in_valid.
  - If count>0 and free!=0: inj_valid=1. inj_sel selects the first free bit searching ptr, ptr+1, ... mod 4.
- Dequeue happens at the clk edge when inj_valid=1. ptr then becomes (granted index + 1) mod 4. ptr holds otherwise.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
- Empty FIFO plus enqueue: no same-cycle injection. Minimum latency from enqueue edge to inj_valid is 0 cycles after the edge, i.e. the flit is visible in the next cycle.
- FIFO pointers wrap modulo DEPTH. Order is strictly FIFO.
- State machine, registered:
  - IDLE: count==0. Goes to PEND on the first enqueue.
  - PEND: count>0, starve counter < STARVE_LIM.
    - Blocked cycle (count>0, free==0): counter +1.
    - Injection: counter cleared.
    - Goes to STARVED when the counter reaches STARVE_LIM.
    - Goes to IDLE when the last flit dequeues with no enqueue.
  - STARVED: starve_req=1 (registered, asserted from the first cycle in STARVED). Counter saturates.
    - On any injection: counter cleared, then PEND if count after update > 0, else IDLE.
    - starve_req deasserts the cycle after that transition.
- The starve counter does not count in IDLE. Exactly STARVE_LIM blocked cycles are needed; the first blocked cycle counts as 1.
- in_valid containing X/Z bits is illegal. The driving wrapper converts an undriven slot to 0 before this block.

Test Plan:
- Reset then idle: rst_n low 2 cycles, no stimulus -> loc_ready=1, inj_valid=0, starve_req=0, occupancy=0.
- Single inject: enqueue 10'h00C, in_valid=4'b1101 -> next cycle inj_valid=1, inj_sel=4'b0010, inj_ad=10'h00C; then occupancy=0 and state IDLE.
- Rotation: enqueue 10'h020, 10'h02C, 10'h03C with in_valid=4'b0000 held -> grants east, west, north (inj_sel 0001, 0010, 0100) on consecutive cycles.
- Full/backpressure: enqueue 4 flits with in_valid=4'b1111 -> loc_ready=0 and occupancy=4. A fifth loc_valid is not accepted, and the FIFO contents stay unchanged.
- Starvation: 1 flit, in_valid=4'b1111 held for 8 cycles -> starve_req=1 from the cycle after the 8th blocked cycle. Then set in_valid=4'b0111 -> inj_sel=4'b1000, starve_req=0 next cycle.
- Async reset mid-burst: rst_n low with occupancy=3 and starve_req=1 -> all outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/inject_scheduler.sv
// Local-injection scheduler: buffers flit addresses from the local core in a
// small FIFO, grants one free router input slot per cycle to the FIFO head
// with rotating priority, and raises a throttle request when the head has
// been blocked for too long.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | FIFO empty; starve counter held at zero
// PEND    | FIFO holds flits; counting consecutive blocked cycles
// STARVED | blocked for STARVE_LIM cycles; starve_req asserted until
//         | the next injection
module inject_scheduler #(
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     loc_valid,
  input  logic [ADDR_W-1:0]        loc_ad,
  output logic                     loc_ready,
  input  logic [3:0]               in_valid,
  output logic                     inj_valid,
  output logic [3:0]               inj_sel,
  output logic [ADDR_W-1:0]        inj_ad,
  output logic                     starve_req,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LIM_C   = 8'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    STARVED = 2'd2
  } state_t;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [7:0]        scnt_q, scnt_d;
  state_t            state_q, state_d;
  logic              starve_req_q, starve_req_d;

  logic [3:0] free;
  logic [1:0] cand;
  logic [1:0] gnt_idx;
  logic       gnt_found;
  logic       push;
  logic       pop;
  logic       blocked;

  // Rotating-priority search for the first free slot starting at ptr.
  always_comb begin
    free      = ~in_valid;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_found && free[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A full FIFO never bypasses: readiness depends only on the stored count.
  assign loc_ready = (count_q < DEPTH_C);
  assign push      = loc_valid && loc_ready;
  assign pop       = (count_q != '0) && gnt_found;
  assign blocked   = (count_q != '0) && (free == 4'b0000);

  assign inj_valid  = pop;
  assign inj_sel    = pop ? (4'b0001 << gnt_idx) : 4'b0000;
  assign inj_ad     = pop ? mem_q[rd_ptr_q] : '0;
  assign starve_req = starve_req_q;
  assign occupancy  = count_q;

  // FIFO storage, pointers, count and priority pointer next-state.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = loc_ad;
    end
    wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ptr_d = pop ? (gnt_idx + 2'd1) : ptr_q;
  end

  // Starvation state machine and starve counter next-state.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      IDLE: begin
        scnt_d = '0;
        if (push) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (pop) begin
          scnt_d = '0;
          if (count_d == '0) begin
            state_d = IDLE;
          end
        end else if (blocked) begin
          scnt_d = scnt_q + 8'd1;
          if (scnt_d >= LIM_C) begin
            state_d = STARVED;
          end
        end
      end
      STARVED: begin
        // Counter saturates while starved; any injection releases the request.
        if (pop) begin
          scnt_d  = '0;
          state_d = (count_d != '0) ? PEND : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        scnt_d  = '0;
      end
    endcase
    starve_req_d = (state_d == STARVED);
  end

  // All state registers; reset discards any buffered flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ptr_q        <= '0;
      scnt_q       <= '0;
      state_q      <= IDLE;
      starve_req_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      scnt_q       <= scnt_d;
      state_q      <= state_d;
      starve_req_q <= starve_req_d;
    end
  end

endmodule

// File: tb/tb_inject_scheduler.sv
// Self-checking bench for inject_scheduler: directed scenarios plus random
// traffic, checked by a scoreboard of expected flit addresses and a small
// behavioural model of slot arbitration and starvation.
module tb_inject_scheduler;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int LIM    = 8;

  logic              clk;
  logic              rst_n;
  logic              loc_valid;
  logic [ADDR_W-1:0] loc_ad;
  logic              loc_ready;
  logic [3:0]        in_valid;
  logic              inj_valid;
  logic [3:0]        inj_sel;
  logic [ADDR_W-1:0] inj_ad;
  logic              starve_req;
  logic [2:0]        occupancy;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] mq[$];
  int m_ptr = 0;
  int m_blk = 0;

  inject_scheduler #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .STARVE_LIM(LIM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .loc_valid(loc_valid),
    .loc_ad(loc_ad),
    .loc_ready(loc_ready),
    .in_valid(in_valid),
    .inj_valid(inj_valid),
    .inj_sel(inj_sel),
    .inj_ad(inj_ad),
    .starve_req(starve_req),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(loc_ready), 32'd1);
    chk({tag, "_inj_valid"}, 32'(inj_valid), 32'd0);
    chk({tag, "_inj_sel"}, 32'(inj_sel), 32'd0);
    chk({tag, "_inj_ad"}, 32'(inj_ad), 32'd0);
    chk({tag, "_starve"}, 32'(starve_req), 32'd0);
    chk({tag, "_occ"}, 32'(occupancy), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  // Monitor/scoreboard: compares every cycle at the falling edge, then
  // advances the reference model to reflect the upcoming rising edge.
  always @(negedge clk) begin : mon
    logic [3:0] fr;
    int         g;
    logic       e_inj;
    logic       acc;
    if (!rst_n) begin
      chk_reset_outputs("mon_rst");
      mq.delete();
      m_ptr = 0;
      m_blk = 0;
    end else begin
      fr = ~in_valid;
      g  = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && fr[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      e_inj = (mq.size() > 0) && (g >= 0);
      chk("ready", 32'(loc_ready), 32'(mq.size() < DEPTH));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("starve_req", 32'(starve_req), 32'(m_blk >= LIM));
      chk("inj_valid", 32'(inj_valid), 32'(e_inj));
      if (e_inj) begin
        chk("inj_sel", 32'(inj_sel), 32'(1) << g);
        chk("inj_ad", 32'(inj_ad), 32'(mq[0]));
      end else begin
        chk("inj_sel_idle", 32'(inj_sel), 32'd0);
        chk("inj_ad_idle", 32'(inj_ad), 32'd0);
      end
      acc = loc_valid && (mq.size() < DEPTH);
      if (e_inj) begin
        void'(mq.pop_front());
        m_ptr = (g + 1) % 4;
        m_blk = 0;
      end else if (mq.size() > 0 && fr == 4'b0000) begin
        if (m_blk < LIM) m_blk++;
      end
      if (acc) mq.push_back(loc_ad);
    end
  end

  initial begin
    rst_n     = 1'b0;
    loc_valid = 1'b0;
    loc_ad    = '0;
    in_valid  = 4'b0000;

    // Reset then idle.
    reset_dut();
    repeat (3) tick();
    chk_reset_outputs("idle");

    // Single inject to the only free slot (west).
    loc_valid = 1'b1; loc_ad = 10'h00C; in_valid = 4'b1101;
    tick();
    loc_valid = 1'b0;
    chk("single_valid", 32'(inj_valid), 32'd1);
    chk("single_sel", 32'(inj_sel), 32'h2);
    chk("single_ad", 32'(inj_ad), 32'h00C);
    tick();
    chk("single_occ", 32'(occupancy), 32'd0);
    chk("single_after", 32'(inj_valid), 32'd0);

    // Rotation from ptr=0 with all slots free.
    reset_dut();
    in_valid = 4'b0000;
    loc_valid = 1'b1; loc_ad = 10'h020;
    tick();
    chk("rot0_sel", 32'(inj_sel), 32'h1);
    chk("rot0_ad", 32'(inj_ad), 32'h020);
    loc_ad = 10'h02C;
    tick();
    chk("rot1_sel", 32'(inj_sel), 32'h2);
    chk("rot1_ad", 32'(inj_ad), 32'h02C);
    loc_ad = 10'h03C;
    tick();
    chk("rot2_sel", 32'(inj_sel), 32'h4);
    chk("rot2_ad", 32'(inj_ad), 32'h03C);
    loc_valid = 1'b0;
    tick();
    chk("rot_occ", 32'(occupancy), 32'd0);

    // Full FIFO and backpressure.
    in_valid = 4'b1111;
    loc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      loc_ad = 10'(10'h101 + i);
      tick();
    end
    chk("full_ready", 32'(loc_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    loc_ad = 10'h3FF;
    tick();
    chk("full_occ_hold", 32'(occupancy), 32'd4);
    loc_valid = 1'b0;
    in_valid  = 4'b0000;
    #1;
    chk("full_head", 32'(inj_ad), 32'h101);
    repeat (5) tick();
    chk("full_drained", 32'(occupancy), 32'd0);

    // Starvation threshold and release.
    in_valid = 4'b1111;
    loc_valid = 1'b1; loc_ad = 10'h155;
    tick();
    loc_valid = 1'b0;
    repeat (7) tick();
    chk("starve_7", 32'(starve_req), 32'd0);
    tick();
    chk("starve_8", 32'(starve_req), 32'd1);
    in_valid = 4'b0111;
    #1;
    chk("starve_rel_valid", 32'(inj_valid), 32'd1);
    chk("starve_rel_sel", 32'(inj_sel), 32'h8);
    tick();
    chk("starve_cleared", 32'(starve_req), 32'd0);
    chk("starve_occ", 32'(occupancy), 32'd0);

    // Asynchronous reset mid-burst.
    in_valid = 4'b1111;
    loc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      loc_ad = 10'(10'h2A1 + i);
      tick();
    end
    loc_valid = 1'b0;
    repeat (8) tick();
    chk("burst_occ", 32'(occupancy), 32'd3);
    chk("burst_starve", 32'(starve_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 4'b0000;

    // Random traffic with periodic fully-blocked bursts.
    for (int cyc = 0; cyc < 800; cyc++) begin
      loc_valid = ($urandom_range(0, 9) < 6);
      loc_ad    = 10'($urandom);
      if ((cyc % 50) < 14) in_valid = 4'b1111;
      else in_valid = 4'($urandom);
      tick();
    end
    loc_valid = 1'b0;
    in_valid  = 4'b0000;
    repeat (6) tick();
    chk("final_occ", 32'(occupancy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
